// File: rtl/branch_predictor.sv
// gshare direction predictor: PC^GHR indexed table of 2-bit saturating counters,
// trained by resolved execute-stage outcomes, with misprediction flagging and perf counters.
module branch_predictor #(
    parameter int INDEX_W = 6,
    parameter int GHR_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pcD,
    input  logic               branchD,
    output logic               pred_takeD,
    output logic [INDEX_W-1:0] pred_indexD,
    input  logic               branchE,
    input  logic               stallE,
    input  logic               flushE,
    input  logic [INDEX_W-1:0] pred_indexE,
    input  logic               pred_takeE,
    input  logic               actual_takeE,
    output logic               mispredictE,
    output logic [31:0]        branch_cnt,
    output logic [31:0]        mispredict_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic [1:0]         pht [ENTRIES];
    logic [GHR_W-1:0]   ghr;
    logic               upd;
    logic [1:0]         upd_ctr;
    logic [1:0]         read_ctr;
    logic               unused_pc;

    assign unused_pc   = ^{pcD[31:INDEX_W+2], pcD[1:0]};
    assign upd         = branchE & ~stallE & ~flushE;
    assign pred_indexD = pcD[INDEX_W+1:2] ^ INDEX_W'(ghr);
    assign mispredictE = branchE & ~flushE & (pred_takeE ^ actual_takeE);

    always_comb begin
        upd_ctr = pht[pred_indexE];
        if (actual_takeE) begin
            if (upd_ctr != 2'b11) upd_ctr = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'b00) upd_ctr = upd_ctr - 2'd1;
        end
    end

    // A decode read of the entry being trained this cycle sees the trained value.
    always_comb begin
        read_ctr = pht[pred_indexD];
        if (upd && (pred_indexD == pred_indexE)) read_ctr = upd_ctr;
        pred_takeD = branchD & read_ctr[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
        end else if (upd) begin
            pht[pred_indexE] <= upd_ctr;
        end
    end

    // Newest outcome enters at bit 0; the cast drops the oldest bit for any GHR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd) begin
            ghr <= GHR_W'({ghr, actual_takeE});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (upd) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (pred_takeE != actual_takeE) mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- gshare direction predictor that supplies a taken/not-taken guess for conditional branches in the decode stage.
- It is trained by the resolved outcome (actual_takeE) from the execute-stage branch comparison.
- It closes the loop with the execute-stage branch check: that unit resolves branches, and this block predicts them and learns from the resolution.
- It also flags mispredictions and keeps performance counters.

Parameters:
INDEX_W, 6, log2 of pattern-table entries; table holds 2^INDEX_W 2-bit saturating counters.
GHR_W, 6, global history length in bits; legal range 1..INDEX_W.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
pcD  input  32  PC of the instruction in decode.
branchD  input  1  decode instruction is a conditional branch.
pred_takeD  output  1  prediction for the decode instruction.
pred_indexD  output  INDEX_W  table index used for this prediction; the pipeline carries it to E.
branchE  input  1  execute instruction is a conditional branch.
stallE  input  1  execute stage held this cycle.
flushE  input  1  execute instruction is squashed.
pred_indexE  input  INDEX_W  pred_indexD carried to E.
pred_takeE  input  1  pred_takeD carried to E.
actual_takeE  input  1  resolved outcome from the branch check.
mispredictE  output  1  prediction was wrong; the front end must redirect.
branch_cnt  output  32  resolved conditional branches since reset.
mispredict_cnt  output  32  mispredictions since reset.

Behaviour:
- Reset (async, rst=1): every table entry = 2'b01 (weakly not taken), GHR = 0, branch_cnt = 0, mispredict_cnt = 0. Reset asserted mid-operation discards all training immediately.
- Index: pred_indexD = pcD[INDEX_W+1:2] XOR {zero-extended GHR}. GHR occupies the low GHR_W bits.
- Prediction (combinational, same cycle as pcD):
  - pred_takeD = branchD & entry[pred_indexD][1].
  - pred_indexD is driven regardless of branchD.
- Update enable: upd = branchE & ~stallE & ~flushE.
  - A branch held in E by a stall updates exactly once, on the cycle stallE drops.
  - A flushed branch never updates.
- Counter update on the rising edge when upd=1, applied to entry[pred_indexE]:
  - actual_takeE=1: increment, saturating at 2'b11.
  - actual_takeE=0: decrement, saturating at 2'b00.
  - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- GHR update on the same edge when upd=1: GHR <= {GHR[GHR_W-2:0], actual_takeE}, newest outcome in bit 0. For GHR_W=1, GHR <= actual_takeE.
- Same-cycle read/write bypass: when upd=1 and pred_indexD == pred_indexE, pred_takeD uses the post-update counter value. GHR is never bypassed; the index always uses the registered GHR.
- mispredictE (combinational) = branchE & ~flushE & (pred_takeE ^ actual_takeE). It is asserted every cycle the condition holds, including stalled cycles.
- Performance counters:
  - When upd=1, branch_cnt += 1.
  - When upd=1 and pred_takeE != actual_takeE, mispredict_cnt += 1.
  - Both wrap modulo 2^32 (0xFFFFFFFF -> 0).
- Table storage is flops with async reset, not RAM. There is no other write port.

Test Plan:
1. Reset, then pcD=0x00400010 with branchD=1 -> pred_takeD=0, pred_indexD=0x04; all counters read 0. Set branchD=0 -> pred_takeD=0.
2. One taken update at index 0x04 (branchE=1, pred_takeE=0, actual_takeE=1, pred_indexE=0x04) -> mispredictE=1 that cycle; entry becomes 10, GHR=0x01, branch_cnt=1, mispredict_cnt=1. Two more taken updates -> entry=11. A fourth taken update -> entry stays 11. One not-taken update -> entry=10, pred still taken.
3. Hold the update of test 2 with stallE=1 for 3 cycles, then stallE=0 -> entry and counters change exactly once; mispredictE=1 for all 4 cycles. The same branch with flushE=1 -> no update, mispredictE=0.
4. After reset, outcomes taken then not-taken -> GHR=0x02. Then pcD=0x00400010 -> pred_indexD=0x06.
5. Bypass: entry[0x05]=01. Apply a taken update at index 0x05 while pcD yields pred_indexD=0x05 -> pred_takeD=1 in that same cycle.
6. Preload branch_cnt=0xFFFFFFFF via a long run (or force), then one update -> branch_cnt=0. Assert rst mid-run -> all outputs and table return to reset values without waiting for a clock.
